// File: rtl/simple_ask_uart_rx.sv
// simple_ask_uart_rx
//   Receive side of the ASK UART link. It consumes the 2-bit symbol stream
//   produced by the ASK UART transmitter. Symbol 2'b00 is a mark (logic 1).
//   Any non-zero symbol (the chopped carrier, 2'b01/2'b11) is a space (logic 0).
//   Frames are 8N1 (start, 8 data bits LSB first, stop). Good bytes are queued
//   in a small byte FIFO for the host.
//
// Parameters
//   SIZE          FIFO depth exponent, capacity 2**SIZE bytes
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   ask_rx_i      demodulated ASK symbol, asynchronous to clk
//   clkdiv_i      baud period in clk cycles, latched at each start bit
//   fifo_out_o    head-of-FIFO byte, valid when fifo_empty_o is low
//   fifo_read_i   pop the head byte; ignored while the FIFO is empty
//   fifo_level_o  number of bytes currently held
//   fifo_empty_o  FIFO holds no bytes
//   frame_err_o   1-cycle pulse: stop bit sampled as space, byte dropped
//   overrun_o     1-cycle pulse: good byte dropped because the FIFO was full
//   sym_err_o     1-cycle pulse: malformed space bit (symbol check builds only)
//   baudclk_o     debug strobe, high when the baud counter is 1
//
// Build option
//   ASK_RX_SYMCHECK_EN  when defined, a bit decided as space must contain both
//                       2'b01 and 2'b11 symbols within its window. Otherwise
//                       sym_err_o pulses and the frame is abandoned. When it is
//                       not defined, any non-zero symbol is a space and
//                       sym_err_o is tied low.

module simple_ask_uart_rx #(
  parameter int SIZE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ask_rx_i,
  input  logic [15:0] clkdiv_i,
  output logic [7:0]  fifo_out_o,
  input  logic        fifo_read_i,
  output logic [15:0] fifo_level_o,
  output logic        fifo_empty_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        sym_err_o,
  output logic        baudclk_o
);

  localparam int DEPTH = 1 << SIZE;
  localparam int PW    = (SIZE > 0) ? SIZE : 1;

  typedef enum logic [1:0] { IDLE, START, DATA, STOP } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync1_q, sync2_q;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_ctr_q, baud_ctr_d;
  logic [15:0] sp_cnt_q, sp_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        push;
  logic        sp, win_end, bit_space, sym_bad;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [15:0]   level_q;
  logic          full, wr_en, rd_en;

  assign sp        = (sync2_q != 2'b00);
  assign win_end   = (baud_ctr_q == div_q);
  // A window is a space when more than half of its samples were non-zero.
  assign bit_space = (sp_cnt_q > (div_q >> 1));

  // Two-flop synchronizer for the asynchronous symbol input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= ask_rx_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef ASK_RX_SYMCHECK_EN
  logic seen01_q, seen01_d, seen11_q, seen11_d, sym_err_q;

  // In IDLE the flags reload from every sample, so a detected start bit
  // begins its window already holding the symbol that triggered it.
  always_comb begin
    seen01_d = seen01_q;
    seen11_d = seen11_q;
    if (state_q == IDLE) begin
      seen01_d = (sync2_q == 2'b01);
      seen11_d = (sync2_q == 2'b11);
    end else if (win_end) begin
      seen01_d = 1'b0;
      seen11_d = 1'b0;
    end else begin
      seen01_d = seen01_q | (sync2_q == 2'b01);
      seen11_d = seen11_q | (sync2_q == 2'b11);
    end
  end

  assign sym_bad = bit_space && !(seen01_q && seen11_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      seen01_q  <= 1'b0;
      seen11_q  <= 1'b0;
      sym_err_q <= 1'b0;
    end else begin
      seen01_q  <= seen01_d;
      seen11_q  <= seen11_d;
      sym_err_q <= (state_q != IDLE) && win_end && sym_bad;
    end
  end

  assign sym_err_o = sym_err_q;
`else
  assign sym_bad   = 1'b0;
  assign sym_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      baud_ctr_q  <= '0;
      sp_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      baud_ctr_q  <= baud_ctr_d;
      sp_cnt_q    <= sp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame sequencing. The sample taken on the decision cycle is dropped, and
  // the counters restart for the next window. The stop decision returns to
  // IDLE, so a new start bit can be picked up on the very next cycle.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    baud_ctr_d  = baud_ctr_q;
    sp_cnt_d    = sp_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        if (sp && (clkdiv_i >= 16'd4)) begin
          div_d      = clkdiv_i;
          baud_ctr_d = 16'd1;
          sp_cnt_d   = 16'd1;
          state_d    = START;
        end
      end
      default: begin
        if (win_end) begin
          baud_ctr_d = 16'd1;
          sp_cnt_d   = 16'd0;
          if (sym_bad) begin
            state_d = IDLE;
          end else begin
            case (state_q)
              START: begin
                if (bit_space) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
                end else begin
                  state_d = IDLE;
                end
              end
              DATA: begin
                shreg_d[bit_idx_q] = ~bit_space;
                bit_idx_d          = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) state_d = STOP;
              end
              STOP: begin
                state_d = IDLE;
                if (bit_space) frame_err_d = 1'b1;
                else           push        = 1'b1;
              end
              default: state_d = IDLE;
            endcase
          end
        end else begin
          baud_ctr_d = baud_ctr_q + 16'd1;
          if (sp && (sp_cnt_q != 16'hFFFF)) sp_cnt_d = sp_cnt_q + 16'd1;
        end
      end
    endcase

    // Park the counters while idle so the debug strobe stays quiet.
    if (state_d == IDLE) begin
      baud_ctr_d = 16'd0;
      sp_cnt_d   = 16'd0;
    end
  end

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Fullness is judged before any same-cycle read, so a pop never makes room
  // for a byte arriving in that same cycle.
  assign full      = (level_q == 16'(DEPTH));
  assign wr_en     = push && !full;
  assign rd_en     = fifo_read_i && (level_q != 16'd0);
  assign overrun_d = push && full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 16'd1;
        2'b01:   level_q <= level_q - 16'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign fifo_out_o   = mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign fifo_empty_o = (level_q == 16'd0);
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign baudclk_o    = (baud_ctr_q == 16'd1);

endmodule

// File: tb/tb_simple_ask_uart_rx.sv
// tb_simple_ask_uart_rx
//   Directed bench for simple_ask_uart_rx with a 4-byte FIFO (SIZE=2).
//   A small transmitter model drives 8N1 frames. Spaces are sent as the
//   chopped carrier, alternating 2'b01/2'b11. Expected bytes go into a
//   scoreboard queue as frames are sent and are compared as they are popped.
//   Error pulses are counted and compared as deltas per scenario.

module tb_simple_ask_uart_rx;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ask_rx;
  logic [15:0] clkdiv;
  logic [7:0]  fifo_out;
  logic        fifo_read;
  logic [15:0] fifo_level;
  logic        fifo_empty;
  logic        frame_err;
  logic        overrun;
  logic        sym_err;
  logic        baudclk;

  int checks = 0;
  int errors = 0;
  int frameErrCnt = 0;
  int overrunCnt = 0;
  int symErrCnt = 0;
  int fe0, ov0, se0;
  int expOv;
  logic [7:0] expQ[$];
  logic chopPhase = 1'b0;

  simple_ask_uart_rx #(.SIZE(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ask_rx_i     (ask_rx),
    .clkdiv_i     (clkdiv),
    .fifo_out_o   (fifo_out),
    .fifo_read_i  (fifo_read),
    .fifo_level_o (fifo_level),
    .fifo_empty_o (fifo_empty),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .sym_err_o    (sym_err),
    .baudclk_o    (baudclk)
  );

  always #5 clk = ~clk;

  // Count every cycle each pulse output is high. A stretched pulse therefore
  // shows up as an extra count.
  always @(negedge clk) begin
    if (frame_err) frameErrCnt <= frameErrCnt + 1;
    if (overrun)   overrunCnt  <= overrunCnt + 1;
    if (sym_err)   symErrCnt   <= symErrCnt + 1;
  end

  // Hard stop in case some wait never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One bit window of the transmitter model.
  // A space is either the chopped carrier or a constant 2'b11.
  task automatic sendBit(input logic b, input logic constSpace);
    for (int i = 0; i < DIV; i++) begin
      if (b)               ask_rx = 2'b00;
      else if (constSpace) ask_rx = 2'b11;
      else begin
        ask_rx    = chopPhase ? 2'b11 : 2'b01;
        chopPhase = ~chopPhase;
      end
      @(negedge clk);
    end
  endtask

  // One full frame. stopSpace forces the stop window to constant 2'b11.
  // bit0Const sends data bit 0 as constant 2'b11 when it is a space.
  // A non-zero midDiv is put on clkdiv while the data bits are in flight.
  task automatic applyStimulus(input logic [7:0] data, input logic stopSpace,
                               input logic bit0Const, input logic [15:0] midDiv);
    sendBit(1'b0, 1'b0);
    if (midDiv != 16'd0) clkdiv = midDiv;
    for (int b = 0; b < 8; b++) sendBit(data[b], (b == 0) && bit0Const);
    sendBit(!stopSpace, stopSpace);
    clkdiv = 16'(DIV);
    ask_rx = 2'b00;
  endtask

  task automatic idle(input int n);
    ask_rx = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    fe0 = frameErrCnt;
    ov0 = overrunCnt;
    se0 = symErrCnt;
  endtask

  task automatic checkPulses(input string tag, input int expFe, input int expOv2,
                             input int expSe);
    checkOutput({tag, "_frame_err"}, 16'(frameErrCnt - fe0), 16'(expFe));
    checkOutput({tag, "_overrun"},   16'(overrunCnt - ov0),  16'(expOv2));
    checkOutput({tag, "_sym_err"},   16'(symErrCnt - se0),   16'(expSe));
  endtask

  task automatic waitLevel(input string tag, input logic [15:0] target,
                           input int budget);
    int n = 0;
    while (fifo_level !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, fifo_level, target);
  endtask

  task automatic readByte(input string tag);
    logic [7:0] exp;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL %s: observed pop expected scoreboard entry", tag);
      $fatal(1, "[TB] scoreboard underflow");
    end
    exp = expQ.pop_front();
    checkOutput({tag, "_not_empty"}, 16'(fifo_empty), 16'd0);
    checkOutput(tag, 16'(fifo_out), 16'(exp));
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ask_rx    = 2'b00;
    clkdiv    = 16'(DIV);
    fifo_read = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_empty",     16'(fifo_empty), 16'd1);
    checkOutput("rst_level",     fifo_level,      16'd0);
    checkOutput("rst_frame_err", 16'(frame_err),  16'd0);
    checkOutput("rst_overrun",   16'(overrun),    16'd0);
    checkOutput("rst_sym_err",   16'(sym_err),    16'd0);
    checkOutput("rst_baudclk",   16'(baudclk),    16'd0);
    rst = 1'b0;
    idle(4);

    // Single byte. clkdiv is disturbed mid-frame and must be ignored.
    $display("[TB] single byte 0xA5");
    snap();
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b0, 1'b0, 16'd7);
    waitLevel("t1_level", 16'd1, 40);
    checkOutput("t1_empty", 16'(fifo_empty), 16'd0);
    idle(4);
    checkPulses("t1", 0, 0, 0);
    readByte("t1_byte");
    checkOutput("t1_drained", 16'(fifo_empty), 16'd1);

    // Back-to-back frames with no idle gap between them.
    $display("[TB] back-to-back 0x00 0xFF 0x55");
    snap();
    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h55);
    applyStimulus(8'h00, 1'b0, 1'b0, 16'd0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 16'd0);
    applyStimulus(8'h55, 1'b0, 1'b0, 16'd0);
    waitLevel("t2_level", 16'd3, 60);
    checkPulses("t2", 0, 0, 0);
    readByte("t2_byte0");
    readByte("t2_byte1");
    readByte("t2_byte2");

    // A short glitch must end as a false start.
    $display("[TB] idle-line glitch");
    snap();
    ask_rx = 2'b01;
    repeat (3) @(negedge clk);
    idle(40);
    checkOutput("t3_level", fifo_level, 16'd0);
    checkPulses("t3", 0, 0, 0);

    // Bad stop bit, followed by a good frame.
    $display("[TB] bad stop bit then 0x12");
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b0, 16'd0);
    idle(8);
`ifdef ASK_RX_SYMCHECK_EN
    checkPulses("t4", 0, 0, 1);
`else
    checkPulses("t4", 1, 0, 0);
`endif
    checkOutput("t4_level", fifo_level, 16'd0);
    expQ.push_back(8'h12);
    applyStimulus(8'h12, 1'b0, 1'b0, 16'd0);
    waitLevel("t4_good_level", 16'd1, 40);
    readByte("t4_byte");

    // Fill the 4-deep FIFO past capacity, then reset mid-frame.
    $display("[TB] overrun and mid-frame reset");
    snap();
    expOv = 0;
    for (int v = 1; v <= 5; v++) begin
      if (expQ.size() < 4) expQ.push_back(8'(v));
      else                 expOv++;
      applyStimulus(8'(v), 1'b0, 1'b0, 16'd0);
      idle(4);
    end
    idle(8);
    checkOutput("t5_level", fifo_level, 16'd4);
    checkPulses("t5", 0, expOv, 0);
    readByte("t5_byte0");
    readByte("t5_byte1");
    snap();
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    rst    = 1'b1;
    ask_rx = 2'b00;
    repeat (2) @(negedge clk);
    expQ.delete();
    checkOutput("t5_rst_empty", 16'(fifo_empty), 16'd1);
    checkOutput("t5_rst_level", fifo_level,      16'd0);
    rst = 1'b0;
    idle(40);
    checkPulses("t5_rst", 0, 0, 0);
    checkOutput("t5_rst_level_after", fifo_level, 16'd0);

    // Data bit 0 sent as constant 2'b11 instead of the chopped carrier.
    $display("[TB] constant-symbol space bit");
    snap();
`ifdef ASK_RX_SYMCHECK_EN
    // The remaining bits are marks, so the abandoned frame's tail cannot
    // look like a new start bit.
    applyStimulus(8'hFE, 1'b0, 1'b1, 16'd0);
    idle(8);
    checkPulses("t6", 0, 0, 1);
    checkOutput("t6_level", fifo_level, 16'd0);
`else
    expQ.push_back(8'h00);
    applyStimulus(8'h00, 1'b0, 1'b1, 16'd0);
    waitLevel("t6_level", 16'd1, 40);
    checkPulses("t6", 0, 0, 0);
    readByte("t6_byte");
`endif

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
